// File: rtl/track_sequencer_pkg.sv
// Shared types and constants for the two-track step sequencer.
// Provides the default note width, the rest code and the FSM state type.
package track_sequencer_pkg;

    localparam int NOTE_W_DEF = 4;
    localparam logic [NOTE_W_DEF-1:0] NOTE_REST = '0;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_state_t;

endpackage

// File: rtl/track_sequencer_step_timer.sv
// Tempo divider: tick pulses for one cycle every TICK_DIV enabled cycles.
// Ports: clk, rst_n (async low), en (count enable, clears when low) -> tick.
module track_sequencer_step_timer #(
    parameter int TICK_DIV = 6_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/track_sequencer.sv
// Two-track loop sequencer: records live notes into the selected track on
// each step tick and plays both tracks back as registered note codes.
// Ports: clk, rst_n (async low), current_track, tracks_playing[1:0],
//   rec_en, key_note -> note_out_0, note_out_1, step_idx, running,
//   plus click when TRACK_SEQ_METRONOME_EN is defined.
module track_sequencer
    import track_sequencer_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = 6_250_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     current_track,
    input  logic [1:0]               tracks_playing,
    input  logic                     rec_en,
    input  logic [NOTE_W-1:0]        key_note,
    output logic [NOTE_W-1:0]        note_out_0,
    output logic [NOTE_W-1:0]        note_out_1,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     running
`ifdef TRACK_SEQ_METRONOME_EN
    ,
    output logic                     click
`endif
);

    localparam int SW = $clog2(DEPTH);

    seq_state_t state, state_next;

    logic              active, tick, go, wr_en;
    logic [1:0]        play_q, play_chg;
    logic [1:0][DEPTH-1:0] valid;
    logic [NOTE_W-1:0] mem0 [DEPTH];
    logic [NOTE_W-1:0] mem1 [DEPTH];
    logic [NOTE_W-1:0] rd0, rd1, nn0, nn1;
    logic [SW-1:0]     step_nxt;

    function automatic logic [NOTE_W-1:0] pick(
        input logic              mon,
        input logic              play,
        input logic [NOTE_W-1:0] rd,
        input logic [NOTE_W-1:0] key
    );
        if (mon) return key;
        if (play) return rd;
        return NOTE_W'(NOTE_REST);
    endfunction

    track_sequencer_step_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == SEQ_RUN),
        .tick (tick)
    );

    assign active   = (|tracks_playing) | rec_en;
    assign go       = (state_next == SEQ_RUN);
    assign wr_en    = tick && rec_en;
    assign play_chg = tracks_playing ^ play_q;
    assign step_nxt = step_idx + SW'(1);
    assign running  = (state == SEQ_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEQ_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SEQ_IDLE: if (active)  state_next = SEQ_RUN;
            SEQ_RUN:  if (!active) state_next = SEQ_IDLE;
            default:               state_next = SEQ_IDLE;
        endcase
    end

    // Data arrays carry no reset so they map onto RAM; valid bits gate them.
    always_ff @(posedge clk) begin
        if (wr_en && !current_track) mem0[step_idx] <= key_note;
        if (wr_en &&  current_track) mem1[step_idx] <= key_note;
    end

    // Read happens alongside the write, so a same-step read sees old data.
    assign rd0 = valid[0][step_idx] ? mem0[step_idx] : '0;
    assign rd1 = valid[1][step_idx] ? mem1[step_idx] : '0;

    always_comb begin
        nn0 = note_out_0;
        nn1 = note_out_1;
        if (!go) begin
            nn0 = '0;
            nn1 = '0;
        end else begin
            if (tick || play_chg[0])
                nn0 = pick(rec_en && !current_track,
                           tracks_playing[0], rd0, key_note);
            if (tick || play_chg[1])
                nn1 = pick(rec_en && current_track,
                           tracks_playing[1], rd1, key_note);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            play_q     <= '0;
            step_idx   <= '0;
            note_out_0 <= '0;
            note_out_1 <= '0;
        end else begin
            play_q     <= tracks_playing;
            note_out_0 <= nn0;
            note_out_1 <= nn1;
            if (wr_en)
                valid[current_track][step_idx] <= (key_note != '0);
            if (!go)
                step_idx <= '0;
            else if (tick)
                step_idx <= step_nxt;
        end
    end

`ifdef TRACK_SEQ_METRONOME_EN
    // Pulse lands with the note update whose new step is a multiple of 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) click <= 1'b0;
        else        click <= tick && go && (step_nxt[1:0] == 2'b00);
    end
`endif

endmodule

// File: tb/tb_track_sequencer.sv
// Self-checking bench for track_sequencer (TICK_DIV=4, DEPTH=8, NOTE_W=4).
// Behavioural loop model plus directed literal checks and random stimulus.
module tb_track_sequencer;

    localparam int TD = 4;
    localparam int DP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ct;
    logic [1:0] tp;
    logic       rec;
    logic [3:0] key;
    logic [3:0] note_out_0, note_out_1;
    logic [2:0] step_idx;
    logic       running;
`ifdef TRACK_SEQ_METRONOME_EN
    logic       click;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    track_sequencer #(
        .NOTE_W  (4),
        .DEPTH   (DP),
        .TICK_DIV(TD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .current_track (ct),
        .tracks_playing(tp),
        .rec_en        (rec),
        .key_note      (key),
        .note_out_0    (note_out_0),
        .note_out_1    (note_out_1),
        .step_idx      (step_idx),
        .running       (running)
`ifdef TRACK_SEQ_METRONOME_EN
        ,
        .click         (click)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Loop model: a track is an array of notes, 0 meaning silent/unrecorded.
    int       m_mem [2][DP];
    int       m_note [2];
    int       m_run, m_phase, m_step, m_click, m_prev_step;
    bit       m_ticked;
    logic [1:0] m_play_q;
    int       mt_tk, mt_nrun;

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_note[k] = 0;
            for (int s = 0; s < DP; s++) m_mem[k][s] = 0;
        end
        m_run = 0; m_phase = 0; m_step = 0; m_click = 0;
        m_prev_step = 0; m_ticked = 0; m_play_q = 2'b00;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            mt_tk   = (m_run != 0 && m_phase == TD - 1) ? 1 : 0;
            mt_nrun = (tp != 2'b00 || rec) ? 1 : 0;
            for (int k = 0; k < 2; k++) begin
                if (mt_nrun == 0)
                    m_note[k] = 0;
                else if (mt_tk != 0 || tp[k] != m_play_q[k])
                    m_note[k] = (rec && int'(ct) == k) ? int'(key) :
                                tp[k] ? m_mem[k][m_step] : 0;
            end
            m_click = (mt_tk != 0 && mt_nrun != 0 &&
                       ((m_step + 1) % DP) % 4 == 0) ? 1 : 0;
            if (mt_tk != 0 && rec) m_mem[int'(ct)][m_step] = int'(key);
            m_ticked    = (mt_tk != 0);
            m_prev_step = m_step;
            if (mt_nrun == 0)    m_step = 0;
            else if (mt_tk != 0) m_step = (m_step + 1) % DP;
            if (mt_nrun == 0 || m_run == 0) m_phase = 0;
            else                            m_phase = (m_phase + 1) % TD;
            m_run    = mt_nrun;
            m_play_q = tp;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("note0", int'(note_out_0), m_note[0]);
            check("note1", int'(note_out_1), m_note[1]);
            check("step", int'(step_idx), m_step);
            check("running", int'(running), m_run);
`ifdef TRACK_SEQ_METRONOME_EN
            check("click", int'(click), m_click);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic lit_idle(input string tag);
        check({tag, "_run"}, int'(running), 0);
        check({tag, "_step"}, int'(step_idx), 0);
        check({tag, "_n0"}, int'(note_out_0), 0);
        check({tag, "_n1"}, int'(note_out_1), 0);
    endtask

    initial begin
        model_clear();
        rst_n = 1'b1; tp = 2'b00; rec = 1'b0; ct = 1'b0; key = 4'd0;
        #1 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        lit_idle("reset");

        // Record track 0: 5 everywhere except step 3 which gets a rest.
        rec = 1'b1; ct = 1'b0;
        repeat (34) begin
            key = (m_step == 3) ? 4'd0 : 4'd5;
            cyc();
            if (m_ticked)
                check("rec_mon0", int'(note_out_0), (m_prev_step == 3) ? 0 : 5);
        end
        check("rec_wrap", int'(step_idx), 0);
        rec = 1'b0; key = 4'd0;
        repeat (2) cyc();
        lit_idle("stop1");

        // Play track 0 only.
        tp = 2'b01;
        repeat (34) begin
            cyc();
            if (m_ticked) begin
                check("play0", int'(note_out_0), (m_prev_step == 3) ? 0 : 5);
                check("play1_mute", int'(note_out_1), 0);
`ifdef TRACK_SEQ_METRONOME_EN
                if (click) check("click_step", int'(step_idx) % 4, 0);
`endif
            end
        end

        // Record track 1 with 1..8 while track 0 keeps playing.
        rec = 1'b1; ct = 1'b1;
        repeat (34) begin
            key = 4'(m_step + 1);
            cyc();
            if (m_ticked)
                check("rec_mon1", int'(note_out_1), m_prev_step + 1);
        end
        rec = 1'b0; key = 4'd0; tp = 2'b11;
        repeat (34) begin
            cyc();
            if (m_ticked) begin
                check("dual1", int'(note_out_1), m_prev_step + 1);
                check("dual0", int'(note_out_0), (m_prev_step == 3) ? 0 : 5);
            end
        end

        tp = 2'b00;
        repeat (3) cyc();
        lit_idle("stop2");
        tp = 2'b11;
        cyc();
        check("replay_n1", int'(note_out_1), 1);
        check("replay_n0", int'(note_out_0), 5);
        repeat (10) cyc();

        // Random traffic.
        repeat (250) begin
            if ($urandom_range(0, 7) == 0) tp = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rec = ~rec;
            if ($urandom_range(0, 9) == 0) ct = ~ct;
            if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
            cyc();
        end

        // Reset in the middle of a running loop drops the recording.
        tp = 2'b11; rec = 1'b0;
        repeat (7) cyc();
        #1 rst_n = 1'b0;
        #1 lit_idle("midrst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (14) begin
            cyc();
            check("lost0", int'(note_out_0), 0);
            check("lost1", int'(note_out_1), 0);
        end

        repeat (250) begin
            if ($urandom_range(0, 7) == 0) tp = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rec = ~rec;
            if ($urandom_range(0, 9) == 0) ct = ~ct;
            if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
            cyc();
        end

        @(posedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
